// File: rtl/dds_pkg.sv
// Shared DDS constants: amplitude/PWM widths, dead-time FSM encoding, duty conversion.
// Latency: none (types, constants and a pure combinational helper).
// Backpressure: not applicable.
package dds_pkg;

   localparam int AMP_W = 16;
   localparam int CNT_W = 10;

   // Dead-time FSM encoding, kept as plain constants so legacy tools can read it.
   localparam logic [1:0] ST_OFF     = 2'd0;
   localparam logic [1:0] ST_DT_WAIT = 2'd1;
   localparam logic [1:0] ST_HI_ON   = 2'd2;
   localparam logic [1:0] ST_LO_ON   = 2'd3;

   localparam logic [AMP_W-1:0] AMP_MSB = {1'b1, {(AMP_W-1){1'b0}}};

   // Signed amplitude -> unsigned duty: flip the sign bit (adds mid-scale offset),
   // then keep the top CNT_W bits. Pure truncation, no rounding.
   function automatic logic [CNT_W-1:0] amp_to_duty(input logic [AMP_W-1:0] amp);
      return CNT_W'((amp ^ AMP_MSB) >> (AMP_W - CNT_W));
   endfunction

endpackage

// File: rtl/pwm_modulator_if.sv
// Bundles the modulator's control input, sample input and pin/debug outputs.
// Latency: none (wires only).
// Backpressure: none; amplitude is a free-running sample stream.
interface pwm_modulator_if;
   import dds_pkg::*;

   logic             en;
   logic [AMP_W-1:0] amplitude;
   logic             pwm_hi;
   logic             pwm_lo;
   logic             period_start;
   logic [CNT_W-1:0] duty_active;

   modport master (
      output en, amplitude,
      input  pwm_hi, pwm_lo, period_start, duty_active
   );

   modport slave (
      input  en, amplitude,
      output pwm_hi, pwm_lo, period_start, duty_active
   );

endinterface

// File: rtl/pwm_deadtime.sv
// Turns the raw PWM level into a complementary hi/lo pin pair with dead-time on every edge.
// Latency: pins follow raw after DEADTIME+1 cycles when turning on, 1 cycle when turning off.
// Backpressure: none; raw is consumed every cycle.
module pwm_deadtime
   import dds_pkg::*;
#(
   parameter int DEADTIME = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic raw_i,
   output logic pwm_hi_o,
   output logic pwm_lo_o
);

   localparam int             DT_W    = $clog2(DEADTIME + 1);
   localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);

   logic [1:0]      state_q, state_d;
   logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
   logic            raw_q, raw_d;
   logic            hi_q, hi_d;
   logic            lo_q, lo_d;

   // Next state: disable wins, then any raw edge restarts the dead-time wait.
   always_comb begin
      state_d  = state_q;
      dt_cnt_d = dt_cnt_q;
      raw_d    = raw_i;
      if (!en_i) begin
         state_d  = ST_OFF;
         dt_cnt_d = '0;
         raw_d    = 1'b0;
      end else if (raw_i != raw_q) begin
         state_d  = ST_DT_WAIT;
         dt_cnt_d = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               // Leaving OFF always goes through a full dead-time window.
               state_d  = ST_DT_WAIT;
               dt_cnt_d = '0;
            end
            ST_DT_WAIT: begin
               dt_cnt_d = dt_cnt_q + 1'b1;
               if (dt_cnt_q == DT_LAST) begin
                  state_d = raw_i ? ST_HI_ON : ST_LO_ON;
               end
            end
            default: begin
            end
         endcase
      end
      hi_d = (state_d == ST_HI_ON);
      lo_d = (state_d == ST_LO_ON);
   end

   // State, dead-time counter, previous raw and registered pins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_OFF;
         dt_cnt_q <= '0;
         raw_q    <= 1'b0;
         hi_q     <= 1'b0;
         lo_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         dt_cnt_q <= dt_cnt_d;
         raw_q    <= raw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign pwm_hi_o = hi_q;
   assign pwm_lo_o = lo_q;

endmodule

// File: rtl/pwm_modulator.sv
// Fixed-period PWM from signed amplitude: double-buffered duty, counter, raw compare, dead-time pins.
// Latency: sample taken at end of period drives raw from the next period; pins lag raw (see pwm_deadtime).
// Backpressure: none; amplitude may change every cycle, only the end-of-period value is used.
module pwm_modulator
   import dds_pkg::*;
#(
   parameter int DEADTIME = 4
) (
   input  logic           clk,
   input  logic           rst,
   pwm_modulator_if.slave bus
);

   localparam logic [CNT_W-1:0] DUTY_MID = {1'b1, {(CNT_W-1){1'b0}}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] duty_next;
   logic             en_q;
   logic             raw_q, raw_d;
   logic             ps_q, ps_d;

   // Counter, duty double buffer, period strobe and raw compare.
   always_comb begin
      duty_next = amp_to_duty(bus.amplitude);
      // Counter stays parked at 0 while disabled and on the enable-rising cycle,
      // so a re-enabled period always begins with a full cnt==0 cycle.
      cnt_d = '0;
      if (bus.en && en_q) begin
         cnt_d = cnt_q + 1'b1;
      end
      // New duty only lands when a period (re)starts; mid-period samples are ignored.
      duty_d = (cnt_d == '0) ? duty_next : duty_q;
      ps_d   = bus.en && (cnt_d == '0);
      // Raw stays low on the enable-rising cycle so the first period is not one cycle long.
      raw_d  = bus.en && en_q && (cnt_q < duty_q);
   end

   // Reset treats the device as already mid-period with mid-scale duty loaded,
   // so holding en high through reset does not reload duty at release.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         duty_q <= DUTY_MID;
         en_q   <= 1'b1;
         raw_q  <= 1'b0;
         ps_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         en_q   <= bus.en;
         raw_q  <= raw_d;
         ps_q   <= ps_d;
      end
   end

   pwm_deadtime #(
      .DEADTIME (DEADTIME)
   ) u_deadtime (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (bus.en),
      .raw_i    (raw_q),
      .pwm_hi_o (bus.pwm_hi),
      .pwm_lo_o (bus.pwm_lo)
   );

   assign bus.period_start = ps_q;
   assign bus.duty_active  = duty_q;

endmodule
